// File: rtl/viterbi_sym_packer.sv
// Viterbi decoder front end: packs 2-bit hard-decision symbols eight per 16-bit
// word, frames them with sof/eof, and buffers words in a small FIFO.
module viterbi_sym_packer #(
  parameter int SYMS_PER_WORD = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sym_in,
  input  logic        sym_valid,
  input  logic        sym_sof,
  input  logic        sym_eof,
  output logic        sym_ready,
  output logic [15:0] data_recv,
  output logic        word_valid,
  output logic        word_last,
  input  logic        word_ready,
  output logic        sof_err,
  input  logic        err_clr,
  output logic [2:0]  fifo_level
);

  localparam int         PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] FULL_LVL  = 3'(FIFO_DEPTH);
  localparam logic [2:0] LAST_SLOT = 3'(SYMS_PER_WORD - 1);

  logic [2:0]       cnt_q, cnt_d;
  logic [15:0]      pack_q, pack_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]       level_q, level_d;
  logic             sof_err_q, sof_err_d;
  logic [15:0]      mem_data_q [FIFO_DEPTH];
  logic             mem_last_q [FIFO_DEPTH];

  logic             accept_s;
  logic             pop_s;
  logic             push_s;
  logic             restart_s;
  logic             complete_s;
  logic [2:0]       base_cnt_s;
  logic [15:0]      base_pack_s;
  logic [15:0]      merged_s;

  // Handshake qualifiers; sym_ready depends only on registered level.
  always_comb begin
    sym_ready  = (level_q != FULL_LVL);
    word_valid = (level_q != 3'd0);
    accept_s   = sym_valid && sym_ready;
    pop_s      = word_valid && word_ready;
  end

  // A sof symbol always starts a fresh word; a non-empty partial is dropped.
  always_comb begin
    base_cnt_s  = cnt_q;
    base_pack_s = pack_q;
    if (sym_sof) begin
      base_cnt_s  = 3'd0;
      base_pack_s = 16'h0000;
    end else begin
      base_cnt_s  = cnt_q;
      base_pack_s = pack_q;
    end
    restart_s  = accept_s && sym_sof && (cnt_q != 3'd0);
    complete_s = (base_cnt_s == LAST_SLOT) || sym_eof;
    push_s     = accept_s && complete_s;
  end

  // Insert the incoming symbol into its slot, first symbol in the top bits.
  always_comb begin
    merged_s = base_pack_s;
    case (base_cnt_s)
      3'd0:    merged_s[15:14] = sym_in;
      3'd1:    merged_s[13:12] = sym_in;
      3'd2:    merged_s[11:10] = sym_in;
      3'd3:    merged_s[9:8]   = sym_in;
      3'd4:    merged_s[7:6]   = sym_in;
      3'd5:    merged_s[5:4]   = sym_in;
      3'd6:    merged_s[3:2]   = sym_in;
      3'd7:    merged_s[1:0]   = sym_in;
      default: merged_s        = base_pack_s;
    endcase
  end

  // Slot counter and pack register next state.
  always_comb begin
    cnt_d  = cnt_q;
    pack_d = pack_q;
    if (accept_s) begin
      if (complete_s) begin
        cnt_d  = 3'd0;
        pack_d = 16'h0000;
      end else begin
        cnt_d  = base_cnt_s + 3'd1;
        pack_d = merged_s;
      end
    end else begin
      cnt_d  = cnt_q;
      pack_d = pack_q;
    end
  end

  // FIFO pointers and occupancy; push never happens when full.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  // Sticky restart error; a new error in the clear cycle wins.
  always_comb begin
    sof_err_d = sof_err_q;
    if (restart_s) begin
      sof_err_d = 1'b1;
    end else if (err_clr) begin
      sof_err_d = 1'b0;
    end else begin
      sof_err_d = sof_err_q;
    end
  end

  // Packer and FIFO control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 3'd0;
      pack_q    <= 16'h0000;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= 3'd0;
      sof_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pack_q    <= pack_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sof_err_q <= sof_err_d;
    end
  end

  // FIFO storage; the pushed word carries eof as its last flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= 16'h0000;
        mem_last_q[i] <= 1'b0;
      end
    end else if (push_s) begin
      mem_data_q[wr_ptr_q] <= merged_s;
      mem_last_q[wr_ptr_q] <= sym_eof;
    end
  end

  assign data_recv  = mem_data_q[rd_ptr_q];
  assign word_last  = mem_last_q[rd_ptr_q];
  assign sof_err    = sof_err_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_viterbi_sym_packer.sv
// Directed self-checking bench for viterbi_sym_packer.
module tb_viterbi_sym_packer;

  logic        clk;
  logic        rst;
  logic [1:0]  sym_in;
  logic        sym_valid;
  logic        sym_sof;
  logic        sym_eof;
  logic        sym_ready;
  logic [15:0] data_recv;
  logic        word_valid;
  logic        word_last;
  logic        word_ready;
  logic        sof_err;
  logic        err_clr;
  logic [2:0]  fifo_level;

  int tests_run    = 0;
  int tests_failed = 0;

  viterbi_sym_packer #(.SYMS_PER_WORD(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_sof(sym_sof), .sym_eof(sym_eof), .sym_ready(sym_ready),
    .data_recv(data_recv), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready), .sof_err(sof_err), .err_clr(err_clr),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a symbol for one edge; inputs stay driven until changed.
  task automatic drive(input logic [1:0] s, input logic sof, input logic eof);
    sym_valid = 1'b1;
    sym_in    = s;
    sym_sof   = sof;
    sym_eof   = eof;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sym_valid = 1'b0;
    sym_sof   = 1'b0;
    sym_eof   = 1'b0;
    sym_in    = 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    tests_run++; if (data_recv !== 16'h0000) begin tests_failed++; $display("FAIL reset_data got %h exp 0000", data_recv); end
    tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", word_valid); end
    tests_run++; if (word_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got %b exp 0", word_last); end
    tests_run++; if (sof_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b exp 0", sof_err); end
    tests_run++; if (sym_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b exp 1", sym_ready); end
    tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_word();
    logic [1:0] syms [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(syms[i], 1'b0, 1'b0);
      if (i < 7) begin
        tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL full_early_valid sym %0d got %b exp 0", i, word_valid); end
      end
    end
    tests_run++; if (word_valid !== 1'b1) begin tests_failed++; $display("FAIL full_valid got %b exp 1", word_valid); end
    tests_run++; if (data_recv !== 16'hE4E4) begin tests_failed++; $display("FAIL full_data got %h exp E4E4", data_recv); end
    tests_run++; if (word_last !== 1'b0) begin tests_failed++; $display("FAIL full_last got %b exp 0", word_last); end
    idle();
    tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL full_one_cycle got %b exp 0", word_valid); end
  endtask

  task automatic test_frame();
    drive(2'd1, 1'b1, 1'b0);
    tests_run++; if (sof_err !== 1'b0) begin tests_failed++; $display("FAIL frame_sof_clean got %b exp 0", sof_err); end
    drive(2'd2, 1'b0, 1'b0);
    drive(2'd3, 1'b0, 1'b1);
    tests_run++; if (word_valid !== 1'b1) begin tests_failed++; $display("FAIL frame_valid got %b exp 1", word_valid); end
    tests_run++; if (data_recv !== 16'h6C00) begin tests_failed++; $display("FAIL frame_data got %h exp 6C00", data_recv); end
    tests_run++; if (word_last !== 1'b1) begin tests_failed++; $display("FAIL frame_last got %b exp 1", word_last); end
    // slot counter must be back at 0: a full word needs exactly 8 more symbols
    for (int i = 0; i < 8; i++) begin
      drive(2'd1, 1'b0, 1'b0);
      if (i < 7) begin
        tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_cnt_early sym %0d got %b exp 0", i, word_valid); end
      end
    end
    tests_run++; if (data_recv !== 16'h5555) begin tests_failed++; $display("FAIL frame_cnt_data got %h exp 5555", data_recv); end
    tests_run++; if (word_last !== 1'b0) begin tests_failed++; $display("FAIL frame_cnt_last got %b exp 0", word_last); end
    idle();
  endtask

  task automatic test_backpressure();
    int          accepted;
    logic [15:0] exp_words [4] = '{16'h5555, 16'hAAAA, 16'hFFFF, 16'h5555};
    accepted   = 0;
    word_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sym_ready === 1'b1) accepted++;
      drive((i < 32) ? 2'(i / 8) : 2'd1, 1'b0, 1'b0);
      tests_run++; if (sym_ready !== (i < 31)) begin tests_failed++; $display("FAIL bp_ready cycle %0d got %b exp %b", i, sym_ready, (i < 31)); end
    end
    tests_run++; if (accepted != 32) begin tests_failed++; $display("FAIL bp_accepted got %0d exp 32", accepted); end
    tests_run++; if (fifo_level !== 3'd4) begin tests_failed++; $display("FAIL bp_level got %0d exp 4", fifo_level); end
    tests_run++; if (data_recv !== 16'h0000) begin tests_failed++; $display("FAIL bp_head got %h exp 0000", data_recv); end
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
    tests_run++; if (sym_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after_pop got %b exp 1", sym_ready); end
    tests_run++; if (fifo_level !== 3'd3) begin tests_failed++; $display("FAIL bp_level_after_pop got %0d exp 3", fifo_level); end
    for (int i = 0; i < 8; i++) drive(2'd1, 1'b0, 1'b0);
    tests_run++; if (fifo_level !== 3'd4) begin tests_failed++; $display("FAIL bp_refill_level got %0d exp 4", fifo_level); end
    tests_run++; if (sym_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_refill_ready got %b exp 0", sym_ready); end
    sym_valid  = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (data_recv !== exp_words[i] || word_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_drain word %0d got %h/%b exp %h/1", i, data_recv, word_valid, exp_words[i]); end
      @(posedge clk);
      #1;
    end
    tests_run++; if (fifo_level !== 3'd0 || word_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_empty got %0d/%b exp 0/0", fifo_level, word_valid); end
  endtask

  task automatic test_sof_restart();
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(2'd1, 1'b0, 1'b0);
    drive(2'd2, 1'b1, 1'b0);
    tests_run++; if (sof_err !== 1'b1) begin tests_failed++; $display("FAIL sof_err_set got %b exp 1", sof_err); end
    tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL sof_no_partial got %b exp 0", word_valid); end
    for (int i = 0; i < 7; i++) begin
      drive(2'd0, 1'b0, 1'b0);
      if (i < 6) begin
        tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL sof_early sym %0d got %b exp 0", i, word_valid); end
      end
    end
    tests_run++; if (data_recv !== 16'h8000 || word_valid !== 1'b1) begin tests_failed++; $display("FAIL sof_word got %h/%b exp 8000/1", data_recv, word_valid); end
    idle();
    tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL sof_single_word got %b exp 0", word_valid); end
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    tests_run++; if (sof_err !== 1'b0) begin tests_failed++; $display("FAIL sof_err_clr got %b exp 0", sof_err); end
    // clear and a fresh restart in the same cycle: the set wins
    drive(2'd1, 1'b0, 1'b0);
    err_clr = 1'b1;
    drive(2'd2, 1'b1, 1'b0);
    err_clr = 1'b0;
    tests_run++; if (sof_err !== 1'b1) begin tests_failed++; $display("FAIL sof_set_wins got %b exp 1", sof_err); end
    drive(2'd1, 1'b0, 1'b1);
    tests_run++; if (data_recv !== 16'h9000 || word_last !== 1'b1) begin tests_failed++; $display("FAIL sof_wins_word got %h/%b exp 9000/1", data_recv, word_last); end
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
  endtask

  task automatic test_single_symbol();
    word_ready = 1'b1;
    drive(2'd3, 1'b1, 1'b1);
    tests_run++; if (data_recv !== 16'hC000 || word_valid !== 1'b1) begin tests_failed++; $display("FAIL single_data got %h/%b exp C000/1", data_recv, word_valid); end
    tests_run++; if (word_last !== 1'b1) begin tests_failed++; $display("FAIL single_last got %b exp 1", word_last); end
    tests_run++; if (sof_err !== 1'b0) begin tests_failed++; $display("FAIL single_err got %b exp 0", sof_err); end
    idle();
  endtask

  task automatic test_reset_mid();
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(2'd2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(2'd3, 1'b0, 1'b0);
    tests_run++; if (data_recv !== 16'hAAAA || word_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pre got %h/%b exp AAAA/1", data_recv, word_valid); end
    sym_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests_run++; if (word_valid !== 1'b0 || data_recv !== 16'h0000 || word_last !== 1'b0) begin tests_failed++; $display("FAIL rstmid_out got %b/%h/%b exp 0/0000/0", word_valid, data_recv, word_last); end
    tests_run++; if (fifo_level !== 3'd0 || sym_ready !== 1'b1 || sof_err !== 1'b0) begin tests_failed++; $display("FAIL rstmid_state got %0d/%b/%b exp 0/1/0", fifo_level, sym_ready, sof_err); end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(2'd1, 1'b0, 1'b0);
      if (i < 7) begin
        tests_run++; if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_early sym %0d got %b exp 0", i, word_valid); end
      end
    end
    tests_run++; if (data_recv !== 16'h5555 || word_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_word got %h/%b exp 5555/1", data_recv, word_valid); end
    idle();
  endtask

  initial begin
    rst        = 1'b0;
    sym_in     = 2'b00;
    sym_valid  = 1'b0;
    sym_sof    = 1'b0;
    sym_eof    = 1'b0;
    word_ready = 1'b0;
    err_clr    = 1'b0;
    test_reset();
    test_full_word();
    test_frame();
    test_backpressure();
    test_sof_restart();
    test_single_symbol();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
